regfile_wb_sched: RTL and testbench

- Write-back scheduler and scoreboard in front of the 32x64 register file write port (RW/BusW/RegWr; negedge write; register 31 reads as zero).
- Shares the single write port between NREQ write-back requesters using valid/ready arbitration.
- Tracks pending destination registers so decode can stall on read-after-write hazards on the RA/RB read ports.

---
 rtl/regfile_wb_sched_pkg.sv | 20 ++
 rtl/regfile_wb_sched_if.sv | 14 +
 rtl/regfile_wb_sched_arb.sv | 57 +++++
 rtl/regfile_wb_sched.sv | 101 ++++++++++
 tb/tb_regfile_wb_sched.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
package regwb_pkg;
   localparam int AW = 5;
   localparam int DW = 64;

   typedef logic [AW-1:0] reg_idx_t;

   // Highest register index is hard-wired to zero and never tracked.
   localparam reg_idx_t REG_ZERO = reg_idx_t'(2**AW - 1);

   typedef struct packed {
      logic           vld;
      reg_idx_t       rd;
      logic [DW-1:0]  data;
   } wb_req_t;

   function automatic logic is_zero_reg(input reg_idx_t r);
      return r == REG_ZERO;
   endfunction
endpackage

// File: rtl/regfile_wb_sched_if.sv
// Write-back request bus: NREQ requesters sharing one register-file write port.
interface regfile_wb_sched_if #(
   parameter int NREQ = 2,
   parameter int AW   = regwb_pkg::AW,
   parameter int DW   = regwb_pkg::DW
);
   logic [NREQ-1:0]    WbVld;
   logic [NREQ*AW-1:0] WbRd;
   logic [NREQ*DW-1:0] WbData;
   logic [NREQ-1:0]    WbRdy;

   modport master (output WbVld, output WbRd, output WbData, input WbRdy);
   modport slave  (input WbVld, input WbRd, input WbData, output WbRdy);
endinterface

// File: rtl/regfile_wb_sched_arb.sv
// Request-to-grant arbiter for the write-back port.
// REGWB_RR_EN defined: round-robin with a pointer; undefined: fixed priority,
// lowest index wins, no pointer state.
module wb_rr_arb #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt
);
   logic w_found;

`ifdef REGWB_RR_EN
   localparam int PW = (NREQ > 2) ? 2 : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_ptr_nxt;

   // Search the requests starting at the pointer; next pointer follows the winner.
   always_comb begin
      gnt       = '0;
      w_found   = 1'b0;
      w_ptr_nxt = r_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
            w_found = 1'b1;
            gnt[(int'(r_ptr) + k) % NREQ] = 1'b1;
            w_ptr_nxt = PW'((int'(r_ptr) + k + 1) % NREQ);
         end
      end
   end

   // Pointer advances only when someone is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr <= '0;
      else if (w_found)
         r_ptr <= w_ptr_nxt;
   end
`else
   logic w_unused;
   assign w_unused = ^{clk, rst_n};

   // Lowest-index valid requester wins.
   always_comb begin
      gnt     = '0;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req[k]) begin
            w_found = 1'b1;
            gnt[k]  = 1'b1;
         end
      end
   end
`endif
endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard in front of the 32x64 register file.
// Arbitrates NREQ write-back requesters onto RW/BusW/RegWr (one-cycle
// registered stage) and tracks pending destinations for RA/RB hazards.
// Macro REGWB_RR_EN selects round-robin arbitration (else fixed priority).
module regfile_wb_sched #(
   parameter int NREQ = 2,
   parameter int DW   = regwb_pkg::DW,
   parameter int AW   = regwb_pkg::AW
) (
   input  logic                Clk,
   input  logic                Reset_n,
   regfile_wb_sched_if.slave   wb,
   input  logic                IssVld,
   input  logic [AW-1:0]       IssRd,
   output logic                IssRdy,
   input  logic [AW-1:0]       RA,
   input  logic [AW-1:0]       RB,
   output logic                HazA,
   output logic                HazB,
   output logic [AW-1:0]       RW,
   output logic [DW-1:0]       BusW,
   output logic                RegWr
);
   import regwb_pkg::*;

   localparam logic [AW-1:0] ZERO_IDX = '1;

   logic [NREQ-1:0]  w_gnt;
   wb_req_t          w_sel;
   logic             w_iss_set;
   logic             r_regwr;
   logic [AW-1:0]    r_rw;
   logic [DW-1:0]    r_busw;
   logic [2**AW-1:0] r_busy;

   wb_rr_arb #(.NREQ(NREQ)) u_arb (
      .clk   (Clk),
      .rst_n (Reset_n),
      .req   (wb.WbVld),
      .gnt   (w_gnt)
   );

   // The write stage always accepts, so the grant is the ready.
   assign wb.WbRdy = w_gnt;

   // Select the granted requester's beat.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_sel.vld  = 1'b1;
            w_sel.rd   = wb.WbRd[i*AW +: AW];
            w_sel.data = wb.WbData[i*DW +: DW];
         end
      end
   end

   assign IssRdy    = !IssVld || (IssRd == ZERO_IDX) || !r_busy[IssRd];
   assign w_iss_set = IssVld && (IssRd != ZERO_IDX) && !r_busy[IssRd];
   assign HazA      = r_busy[RA] && (RA != ZERO_IDX);
   assign HazB      = r_busy[RB] && (RB != ZERO_IDX);
   assign RW        = r_rw;
   assign BusW      = r_busw;
   assign RegWr     = r_regwr;

   // Write stage: register the accepted beat; writes to the zero register are dropped.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_regwr <= 1'b0;
         r_rw    <= '0;
         r_busw  <= '0;
      end else begin
         r_regwr <= w_sel.vld && (w_sel.rd != ZERO_IDX);
         if (w_sel.vld) begin
            r_rw   <= w_sel.rd;
            r_busw <= w_sel.data;
         end
      end
   end

   // Scoreboard: clear after the file write commits, set on accepted issue (set wins).
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_busy <= '0;
      end else begin
         if (r_regwr)
            r_busy[r_rw] <= 1'b0;
         if (w_iss_set)
            r_busy[IssRd] <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   // A stalled requester must hold its destination and data.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold
      a_hold: assert property (@(posedge Clk) disable iff (!Reset_n)
         (wb.WbVld[gi] && !wb.WbRdy[gi]) |=>
            ($stable(wb.WbRd[gi*AW +: AW]) && $stable(wb.WbData[gi*DW +: DW])));
   end
`endif
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios followed by
// randomized write-back/issue traffic against a behavioural model.
module tb_regfile_wb_sched;
   import regwb_pkg::*;

   localparam int NREQ = 2;

   logic            Clk = 1'b0;
   logic            Reset_n;
   logic            IssVld;
   logic [AW-1:0]   IssRd;
   logic            IssRdy;
   logic [AW-1:0]   RA;
   logic [AW-1:0]   RB;
   logic            HazA;
   logic            HazB;
   logic [AW-1:0]   RW;
   logic [DW-1:0]   BusW;
   logic            RegWr;

   regfile_wb_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wb ();

   regfile_wb_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .wb      (wb),
      .IssVld  (IssVld),
      .IssRd   (IssRd),
      .IssRdy  (IssRdy),
      .RA      (RA),
      .RB      (RB),
      .HazA    (HazA),
      .HazB    (HazB),
      .RW      (RW),
      .BusW    (BusW),
      .RegWr   (RegWr)
   );

   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0]     m_busy;
   logic            m_regwr;
   logic [AW-1:0]   m_rw;
   logic [DW-1:0]   m_busw;
   int              m_last;

   // Requester-side pending beats
   logic            p_vld  [NREQ];
   logic [AW-1:0]   p_rd   [NREQ];
   logic [DW-1:0]   p_data [NREQ];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      m_busy  = '0;
      m_regwr = 1'b0;
      m_rw    = '0;
      m_busw  = '0;
      m_last  = NREQ - 1;
      for (int i = 0; i < NREQ; i++) p_vld[i] = 1'b0;
   endtask

   task automatic arm(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
      p_vld[i]  = 1'b1;
      p_rd[i]   = rd;
      p_data[i] = data;
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < NREQ; i++) begin
         wb.WbVld[i]             = p_vld[i];
         wb.WbRd[i*AW +: AW]     = p_rd[i];
         wb.WbData[i*DW +: DW]   = p_data[i];
      end
   endtask

   // One clock: drive, compare every output against the model, advance the model.
   task automatic step();
      int              g;
      logic [NREQ-1:0] e_rdy;
      logic            e_iss;
      logic [31:0]     nb;
      apply_inputs();
      #1;
      g = -1;
`ifdef REGWB_RR_EN
      // The next pending requester after the previous winner, wrapping around.
      for (int k = 1; k <= NREQ; k++)
         if (g < 0 && p_vld[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
`else
      for (int k = 0; k < NREQ; k++)
         if (g < 0 && p_vld[k]) g = k;
`endif
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      e_iss = !IssVld || is_zero_reg(IssRd) || !m_busy[IssRd];
      check("wbrdy",  64'(wb.WbRdy), 64'(e_rdy));
      check("issrdy", 64'(IssRdy), 64'(e_iss));
      check("haza",   64'(HazA), 64'(m_busy[RA] && !is_zero_reg(RA)));
      check("hazb",   64'(HazB), 64'(m_busy[RB] && !is_zero_reg(RB)));
      check("regwr",  64'(RegWr), 64'(m_regwr));
      check("rw",     64'(RW), 64'(m_rw));
      check("busw",   BusW, m_busw);
      nb = m_busy;
      if (m_regwr) nb[m_rw] = 1'b0;
      if (IssVld && !is_zero_reg(IssRd) && e_iss) nb[IssRd] = 1'b1;
      if (g >= 0) begin
         m_regwr  = !is_zero_reg(p_rd[g]);
         m_rw     = p_rd[g];
         m_busw   = p_data[g];
         m_last   = g;
         p_vld[g] = 1'b0;
      end else begin
         m_regwr = 1'b0;
      end
      m_busy = nb;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      logic [AW-1:0] r;
      Reset_n = 1'b0;
      IssVld  = 1'b0;
      IssRd   = '0;
      RA      = 5'd3;
      RB      = 5'd4;
      for (int i = 0; i < NREQ; i++) begin
         p_rd[i]   = '0;
         p_data[i] = '0;
      end
      mdl_reset();
      apply_inputs();
      #2;
      check("rst_regwr", 64'(RegWr), 64'd0);
      check("rst_rw",    64'(RW), 64'd0);
      check("rst_busw",  BusW, 64'd0);
      check("rst_haza",  64'(HazA), 64'd0);
      check("rst_issrdy", 64'(IssRdy), 64'd1);
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;

      // Single beat from the ALU requester
      arm(0, 5'd5, 64'hDEAD);
      step();
      check("t1_regwr", 64'(RegWr), 64'd1);
      check("t1_rw",    64'(RW), 64'd5);
      check("t1_busw",  BusW, 64'hDEAD);
      step();
      check("t1_drop",  64'(RegWr), 64'd0);

      // Both requesters continuously valid
      arm(0, 5'd3, 64'h3333);
      arm(1, 5'd4, 64'h4444);
      for (int k = 0; k < 6; k++) begin
         step();
`ifdef REGWB_RR_EN
         check("t2_rw", 64'(RW), (k % 2 == 0) ? 64'd4 : 64'd3);
`else
         check("t2_rw", 64'(RW), 64'd3);
`endif
         if (!p_vld[0]) arm(0, 5'd3, 64'h3333);
         if (!p_vld[1]) arm(1, 5'd4, 64'h4444);
      end
      p_vld[0] = 1'b0;
      p_vld[1] = 1'b0;
      step();
      step();

      // Issue to 7, hazard, blocked re-issue, clear by write-back
      IssVld = 1'b1; IssRd = 5'd7; RA = 5'd7;
      step();
      check("t3_haz",  64'(HazA), 64'd1);
      check("t3_stall", 64'(IssRdy), 64'd0);
      step();
      IssVld = 1'b0;
      arm(0, 5'd7, 64'h7777);
      step();
      step();
      check("t3_clr", 64'(HazA), 64'd0);

      // Zero register: write dropped, issue never marks busy
      arm(0, 5'd31, 64'h3131);
      step();
      check("t4_nowr", 64'(RegWr), 64'd0);
      IssVld = 1'b1; IssRd = 5'd31; RA = 5'd31;
      step();
      check("t4_haz", 64'(HazA), 64'd0);
      IssVld = 1'b0;

      // Set of 9 coinciding with the clear of 9: set wins
      arm(0, 5'd9, 64'h9999);
      step();
      IssVld = 1'b1; IssRd = 5'd9; RA = 5'd9;
      step();
      IssVld = 1'b0;
      check("t5_setwins", 64'(HazA), 64'd1);
      step();

      // Asynchronous reset while a write is in flight and bits are pending
      IssVld = 1'b1; IssRd = 5'd10;
      step();
      IssRd = 5'd11;
      step();
      IssVld = 1'b0;
      arm(0, 5'd12, 64'h1212);
      step();
      RA = 5'd10; RB = 5'd11;
      #1;
      check("t6_pre_regwr", 64'(RegWr), 64'd1);
      check("t6_pre_haza",  64'(HazA), 64'd1);
      check("t6_pre_hazb",  64'(HazB), 64'd1);
      #1;
      Reset_n = 1'b0;
      #1;
      check("t6_regwr", 64'(RegWr), 64'd0);
      check("t6_haza",  64'(HazA), 64'd0);
      check("t6_hazb",  64'(HazB), 64'd0);
      check("t6_rw",    64'(RW), 64'd0);
      mdl_reset();
      apply_inputs();
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!p_vld[i] && ($urandom % 3 == 0)) begin
               r = AW'($urandom % 32);
               if ($urandom % 2 == 0)
                  for (int t = 0; t < 32 && !m_busy[r]; t++) r = AW'($urandom % 32);
               arm(i, r, {$urandom, $urandom});
            end
         end
         IssVld = ($urandom % 2 == 0);
         IssRd  = AW'($urandom % 32);
         RA     = AW'($urandom % 32);
         RB     = AW'($urandom % 32);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
